// File: rtl/chacha20_stream_ctrl_pkg.sv
// Shared ChaCha20 stream-path types: keystream word, block geometry and controller states.
package chacha20_stream_ctrl_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned BLK_WORDS = 16;
    localparam int unsigned BLK_BYTES = 64;
    localparam int unsigned BLK_SH    = $clog2(BLK_BYTES);
    localparam int unsigned WIDX_W    = $clog2(BLK_WORDS);
    localparam int unsigned BIDX_W    = $clog2(BLK_BYTES);
    localparam int unsigned BLEFT_W   = BIDX_W + 1;
    localparam int unsigned CTR_W     = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_LOAD,
        ST_XOR,
        ST_FIN
    } ctrl_state_t;

endpackage

// File: rtl/chacha20_stream_ctrl_ks_buffer.sv
// One keystream block: 16x32 word-write register file with a byte-addressed read port.
module chacha20_stream_ctrl_ks_buffer
    import chacha20_stream_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [WIDX_W-1:0] widx,
    input  word_t             wdata,
    input  logic [BIDX_W-1:0] bidx,
    output logic [7:0]        rd_byte_c
);

    word_t mem [BLK_WORDS];
    word_t rd_word_c;

    // Word write from the block core; contents need no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    // Byte select: word bidx>>2, little-endian byte bidx&3.
    always_comb begin
        rd_word_c = mem[bidx[BIDX_W-1:2]];
        rd_byte_c = rd_word_c[{bidx[1:0], 3'b000} +: 8];
    end

endmodule

// File: rtl/chacha20_stream_ctrl.sv
// ChaCha20 stream controller: requests keystream blocks, buffers them and XORs plaintext bytes.
module chacha20_stream_ctrl
    import chacha20_stream_ctrl_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CTR_W-1:0] ctr_init,
    input  logic [LEN_W-1:0] msg_len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             blk_req,
    output logic [CTR_W-1:0] blk_ctr,
    input  logic             ks_valid,
    input  word_t            ks_word,
    input  logic             pt_valid,
    output logic             pt_ready,
    input  logic [7:0]       pt_data,
    output logic             ct_valid,
    input  logic             ct_ready,
    output logic [7:0]       ct_data,
    output logic             ct_last
);

    localparam int unsigned LEXT_W = LEN_W + 1;
    localparam int unsigned CEXT_W = CTR_W + 1;

    ctrl_state_t        state;
    logic [CTR_W-1:0]   ctr;
    logic [LEN_W-1:0]   msg_rem;
    logic [BLEFT_W-1:0] bytes_left;
    logic [WIDX_W-1:0]  widx;
    logic [BIDX_W-1:0]  bidx;

    logic [LEXT_W-1:0]  nblk_c;
    logic               ovf_c;
    logic [BLEFT_W-1:0] first_left_c;
    logic               ct_free_c;
    logic               pt_fire_c;
    logic               ks_we_c;
    logic               last_byte_c;
    logic [7:0]         ks_byte_c;

    // Start-time checks: block count, counter overflow, and the size of the next block window.
    always_comb begin
        nblk_c       = (LEXT_W'(msg_len) + LEXT_W'(BLK_BYTES - 1)) >> BLK_SH;
        ovf_c        = (CEXT_W'(ctr_init) + CEXT_W'(nblk_c) - CEXT_W'(1)) > CEXT_W'({CTR_W{1'b1}});
        first_left_c = (msg_rem >= LEN_W'(BLK_BYTES)) ? BLEFT_W'(BLK_BYTES) : BLEFT_W'(msg_rem);
        ct_free_c    = !ct_valid || ct_ready;
        ks_we_c      = (state == ST_LOAD) && ks_valid;
        last_byte_c  = (msg_rem == LEN_W'(1));
        pt_fire_c    = pt_valid && pt_ready;
    end

    assign pt_ready = (state == ST_XOR) && (bytes_left != '0) && ct_free_c;

    chacha20_stream_ctrl_ks_buffer u_ks_buffer (
        .clk       (clk),
        .we        (ks_we_c),
        .widx      (widx),
        .wdata     (ks_word),
        .bidx      (bidx),
        .rd_byte_c (ks_byte_c)
    );

    // Message sequencing FSM with registered control outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            ctr        <= '0;
            msg_rem    <= '0;
            bytes_left <= '0;
            widx       <= '0;
            bidx       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            blk_req    <= 1'b0;
            blk_ctr    <= '0;
        end else begin
            done    <= 1'b0;
            blk_req <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        ctr     <= ctr_init;
                        msg_rem <= msg_len;
                        if (msg_len == '0) begin
                            err   <= 1'b0;
                            busy  <= 1'b1;
                            state <= ST_FIN;
                        end else if (ovf_c) begin
                            err <= 1'b1;
                        end else begin
                            err     <= 1'b0;
                            busy    <= 1'b1;
                            blk_req <= 1'b1;
                            blk_ctr <= ctr_init;
                            state   <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    widx  <= '0;
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (ks_valid) begin
                        widx <= widx + WIDX_W'(1);
                        if (widx == WIDX_W'(BLK_WORDS - 1)) begin
                            bidx       <= '0;
                            bytes_left <= first_left_c;
                            state      <= ST_XOR;
                        end
                    end
                end
                ST_XOR: begin
                    if (pt_fire_c) begin
                        bidx       <= bidx + BIDX_W'(1);
                        bytes_left <= bytes_left - BLEFT_W'(1);
                        msg_rem    <= msg_rem - LEN_W'(1);
                        if (last_byte_c) begin
                            state <= ST_FIN;
                        end else if (bytes_left == BLEFT_W'(1)) begin
                            ctr     <= ctr + CTR_W'(1);
                            blk_req <= 1'b1;
                            blk_ctr <= ctr + CTR_W'(1);
                            state   <= ST_REQ;
                        end
                    end
                end
                ST_FIN: begin
                    if (ct_free_c) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Ciphertext output register: load on plaintext accept, hold under stall, clear on drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ct_valid <= 1'b0;
            ct_data  <= '0;
            ct_last  <= 1'b0;
        end else if (pt_fire_c) begin
            ct_valid <= 1'b1;
            ct_data  <= pt_data ^ ks_byte_c;
            ct_last  <= last_byte_c;
        end else if (ct_valid && ct_ready) begin
            ct_valid <= 1'b0;
            ct_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_chacha20_stream_ctrl.sv
// Scoreboard bench for chacha20_stream_ctrl with a behavioural keystream core model.
`timescale 1ns/1ps
module tb_chacha20_stream_ctrl;

    localparam int unsigned LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      ctr_init = '0;
    logic [LEN_W-1:0] msg_len = '0;
    logic             busy;
    logic             done;
    logic             err;
    logic             blk_req;
    logic [31:0]      blk_ctr;
    logic             ks_valid = 1'b0;
    logic [31:0]      ks_word = '0;
    logic             pt_valid = 1'b0;
    logic             pt_ready;
    logic [7:0]       pt_data = '0;
    logic             ct_valid;
    logic             ct_ready = 1'b1;
    logic [7:0]       ct_data;
    logic             ct_last;

    int checks = 0;
    int errors = 0;
    int gap_pct = 0;

    logic [8:0]  exp_ct[$];
    logic [31:0] exp_req[$];
    logic [31:0] core_q[$];

    chacha20_stream_ctrl #(.LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ctr_init (ctr_init),
        .msg_len  (msg_len),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .blk_req  (blk_req),
        .blk_ctr  (blk_ctr),
        .ks_valid (ks_valid),
        .ks_word  (ks_word),
        .pt_valid (pt_valid),
        .pt_ready (pt_ready),
        .pt_data  (pt_data),
        .ct_valid (ct_valid),
        .ct_ready (ct_ready),
        .ct_data  (ct_data),
        .ct_last  (ct_last)
    );

    always #5 clk = ~clk;

    // Keystream word i of block c as the model core produces it.
    function automatic logic [31:0] ks_fn(input logic [31:0] c, input int i);
        return (c * 32'h9E37_79B1) ^ (32'(i) * 32'h85EB_CA77) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},     64'(busy),     64'd0);
        chk({tag, "_done"},     64'(done),     64'd0);
        chk({tag, "_err"},      64'(err),      64'd0);
        chk({tag, "_blk_req"},  64'(blk_req),  64'd0);
        chk({tag, "_blk_ctr"},  64'(blk_ctr),  64'd0);
        chk({tag, "_pt_ready"}, 64'(pt_ready), 64'd0);
        chk({tag, "_ct_valid"}, 64'(ct_valid), 64'd0);
        chk({tag, "_ct_data"},  64'(ct_data),  64'd0);
        chk({tag, "_ct_last"},  64'(ct_last),  64'd0);
    endtask

    // Block core model: serves queued requests with 16 beats, random gaps, noise when idle.
    initial begin
        logic [31:0] cur;
        int beat;
        bit active;
        cur = '0;
        beat = 0;
        active = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                active = 1'b0;
                core_q.delete();
                ks_valid = 1'b0;
            end else begin
                if (!active && core_q.size() != 0) begin
                    cur = core_q.pop_front();
                    beat = 0;
                    active = 1'b1;
                end
                ks_valid = 1'b0;
                if (active) begin
                    if (int'($urandom_range(0, 99)) >= gap_pct) begin
                        ks_valid = 1'b1;
                        ks_word = ks_fn(cur, beat);
                        beat++;
                        if (beat == 16) active = 1'b0;
                    end
                end else if ($urandom_range(0, 99) < 20) begin
                    ks_valid = 1'b1;
                    ks_word = $urandom;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every ct handshake and blk_req, checks stall stability.
    initial begin
        bit stall_d;
        logic [7:0] d_hold;
        logic l_hold;
        logic [8:0] e;
        logic [31:0] r;
        stall_d = 1'b0;
        d_hold = '0;
        l_hold = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stall_d = 1'b0;
            end else begin
                if (stall_d) begin
                    chk("ct_hold_valid", 64'(ct_valid), 64'd1);
                    chk("ct_hold_data", 64'({ct_last, ct_data}), 64'({l_hold, d_hold}));
                end
                if (ct_valid && ct_ready) begin
                    if (exp_ct.size() == 0) begin
                        chk("ct_unexpected", 64'({ct_last, ct_data}), 64'h1FF_FFFF);
                    end else begin
                        e = exp_ct.pop_front();
                        chk("ct_byte", 64'({ct_last, ct_data}), 64'(e));
                    end
                end
                if (pt_ready && ct_valid && !ct_ready) begin
                    chk("pt_ready_under_stall", 64'(pt_ready), 64'd0);
                end
                if (blk_req) begin
                    core_q.push_back(blk_ctr);
                    if (exp_req.size() == 0) begin
                        chk("blk_req_unexpected", 64'(blk_ctr), 64'h1_0000_0000);
                    end else begin
                        r = exp_req.pop_front();
                        chk("blk_ctr", 64'(blk_ctr), 64'(r));
                    end
                end
                stall_d = ct_valid && !ct_ready;
                d_hold = ct_data;
                l_hold = ct_last;
            end
        end
    end

    // Issue one message; expected blocks and ciphertext go to the scoreboard at issue time.
    task automatic run_msg(input logic [31:0] c0, input int len, input bit seq_pt,
                           input int rdy_pct, input int pv_pct, input int abort_at,
                           input bit poke);
        logic [7:0] pt[$];
        logic [31:0] ks;
        int nblk;
        int sent;
        int cyc;
        int last_cyc;
        bit ovf;
        bit got_done;

        nblk = (len + 63) / 64;
        ovf = (len != 0) && ((longint'(c0) + longint'(nblk) - 1) > 64'hFFFF_FFFF);
        for (int j = 0; j < len; j++) begin
            pt.push_back(seq_pt ? 8'(j) : 8'($urandom));
        end
        if (!ovf) begin
            for (int b = 0; b < nblk; b++) exp_req.push_back(c0 + 32'(b));
            for (int j = 0; j < len; j++) begin
                ks = ks_fn(c0 + 32'(j / 64), (j % 64) / 4);
                exp_ct.push_back({(j == len - 1), pt[j] ^ ks[8 * (j % 4) +: 8]});
            end
        end

        @(posedge clk);
        #1;
        start = 1'b1;
        ctr_init = c0;
        msg_len = LEN_W'(len);
        pt_valid = 1'b0;
        ct_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;

        if (ovf) begin
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                chk("ovf_busy_low", 64'(busy), 64'd0);
            end
            chk("ovf_err_set", 64'(err), 64'd1);
            return;
        end

        sent = 0;
        cyc = 0;
        last_cyc = -10;
        got_done = 1'b0;
        while (!got_done && cyc < 200 + 40 * len) begin
            pt_valid = (sent < len) && (int'($urandom_range(0, 99)) < pv_pct);
            pt_data = (sent < len) ? pt[sent] : 8'h00;
            ct_ready = int'($urandom_range(0, 99)) < rdy_pct;
            start = poke && (cyc == 3);
            ctr_init = poke ? 32'hDEAD_0000 : c0;
            @(negedge clk);
            if (cyc == 0) begin
                chk("busy_rise", 64'(busy), 64'd1);
                chk("err_clear", 64'(err), 64'd0);
            end
            if (pt_valid && pt_ready) sent++;
            if (ct_valid && ct_ready && ct_last) last_cyc = cyc;
            if (done) begin
                got_done = 1'b1;
                chk("done_latency", 64'(cyc), 64'(len == 0 ? 1 : last_cyc + 1));
                chk("busy_fall", 64'(busy), 64'd0);
                chk("pt_count", 64'(sent), 64'(len));
                chk("ct_drained", 64'(exp_ct.size()), 64'd0);
                chk("req_drained", 64'(exp_req.size()), 64'd0);
            end else if (abort_at >= 0 && sent == abort_at) begin
                #1 rst = 1'b0;
                #1 chk_reset_outputs("midrst");
                exp_ct.delete();
                exp_req.delete();
                pt_valid = 1'b0;
                start = 1'b0;
                ct_ready = 1'b1;
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: actual=no done after %0d cycles required=done", cyc);
        end
        pt_valid = 1'b0;
        ct_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("done_single", 64'(done), 64'd0);
        end
    endtask

    // Directed boundary cases followed by randomized messages.
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("por");
        rst = 1'b1;

        gap_pct = 0;
        run_msg(32'd1, 64, 1'b1, 100, 100, -1, 1'b0);
        run_msg(32'd7, 65, 1'b0, 100, 100, -1, 1'b0);
        run_msg(32'd123, 0, 1'b0, 100, 100, -1, 1'b0);
        run_msg(32'hFFFF_FFFF, 65, 1'b0, 100, 100, -1, 1'b0);
        run_msg(32'd0, 1, 1'b0, 100, 100, -1, 1'b0);
        run_msg(32'hFFFF_FFFE, 129, 1'b0, 100, 100, -1, 1'b0);
        run_msg(32'hFFFF_FFFF, 64, 1'b0, 100, 100, -1, 1'b0);

        gap_pct = 50;
        run_msg($urandom, 10, 1'b0, 50, 70, -1, 1'b0);

        gap_pct = 20;
        run_msg(32'd100, 64, 1'b0, 100, 100, 30, 1'b0);
        run_msg(32'd200, 64, 1'b0, 80, 90, -1, 1'b1);

        for (int n = 0; n < 6; n++) begin
            gap_pct = int'($urandom_range(0, 60));
            run_msg($urandom, int'($urandom_range(1, 200)), 1'b0,
                    int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
